idct_blk_feeder: RTL and testbench
==================================

Name: idct_blk_feeder

Overview:
Upstream feeder for the IDCT multiplier stage. Accepts dequantized coefficients serially in JPEG zigzag order and de-zigzags them into a ping-pong pair of 8x8 block buffers. Emits each buffered block as 8 row vectors of 8x32-bit lanes, the 256-bit vector format the IDCT multiplier consumes. One block can be written while the other is read out.

Parameters:
COEF_W, 16, input coefficient width (two's complement)
LANE_W, 32, output lane width; fixed, 8*LANE_W = 256

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
coef_in  in  COEF_W  dequantized coefficient, signed
coef_valid  in  1  coef_in valid
coef_ready  out  1  feeder can accept coef_in this cycle
row_data  out  256  lane k at [32k+31:32k] = natural coefficient (row_idx*8+k), sign-extended to 32 bits
row_idx  out  3  row number 0..7 of row_data
row_last  out  1  high with row_idx==7
row_valid  out  1  row_data valid
row_ready  in  1  downstream accepts row

Behaviour:
- Reset (async assert, sync release): both banks EMPTY, write bank = 0, write count = 0, read bank = 0, read row = 0. row_valid, row_data, row_idx and row_last = 0. coef_ready = 1 after release.
- Bank state per bank: EMPTY -> FILLING (first write) -> FULL (64th write accepted) -> READING (first row loaded) -> EMPTY (row 7 handshake).
- Write side:
  - Handshake = coef_valid & coef_ready.
  - coef_ready = current write bank is EMPTY or FILLING; combinational from registered state only, with no path from coef_valid.
  - Address = zigzag-to-natural LUT[count], standard JPEG order: 0,1,8,16,9,2,3,10,17,24,... ending 63.
  - On the 64th handshake: bank goes FULL, write bank toggles, count returns to 0.
  - If the other bank is not EMPTY, coef_ready = 0 until it frees.
- Read side:
  - Output register loads when (!row_valid | row_ready) and the read bank is FULL or READING with rows remaining.
  - row_data, row_idx and row_last are stable while row_valid & !row_ready.
  - Rows are emitted 0..7. Back-to-back throughput is 1 row/cycle.
  - After the row 7 handshake: bank goes EMPTY, read bank toggles.
- Latency: row 0 of a block has row_valid high the cycle after the 64th coefficient handshake, if the output register is free.
- Simultaneous events:
  - Write to one bank and read from the other in the same cycle is legal.
  - Bank freed by a row 7 handshake in cycle N: coef_ready may rise in cycle N+1, not in cycle N.
  - A bank becoming FULL in the same cycle the other bank frees: reading continues seamlessly with no bubble required, and none permitted beyond the 1-cycle load.
- Sign extension: lane = {{(32-COEF_W){coef[COEF_W-1]}}, coef}.
- coef_valid while coef_ready=0: the coefficient is held upstream, not dropped. No internal overflow is possible.
- Reset mid-block discards all buffered data. No partial row is emitted after release.

Optional Feature:
Macro IDCT_FEED_EOB_EN.
- Defined:
  - Adds input port coef_eob (1 bit), qualified by the coef_valid handshake.
  - That beat's coefficient is written, then the block is complete: bank goes FULL immediately and all unwritten positions read as 0.
  - Implemented with a per-bank 64-bit written-mask, cleared when the bank goes EMPTY.
  - coef_eob on the 64th beat behaves as a normal completion.
- Not defined: no coef_eob port. Exactly 64 beats per block are required, and no mask logic is present.

Test Plan:
1. Reset then 64 beats with coef_in = zigzag index (0..63), row_ready=1 -> rows 0..7 out on consecutive cycles starting 1 cycle after beat 63. Row 0 lanes = 0,1,5,6,14,15,27,28. Row 1 lane 0 = 2. Row 7 lane 7 = 63. row_last only on row 7.
2. Negative value: coef_in=16'h8001 at zz index 2 -> row 1 lane 0 = 32'hFFFF8001.
3. Backpressure: row_ready=0 for 20 cycles mid-block -> row_data stable, no row skipped or duplicated.
4. Ping-pong stall: stream 3 blocks continuously with row_ready=0 -> coef_ready falls after 128 beats. Release row_ready -> coef_ready rises the cycle after the first bank's row 7 handshake. Third block is intact.
5. Async reset asserted mid-read (row 3) -> all outputs 0 immediately. After release, a fresh block reads out correctly with row_idx starting at 0.
6. (IDCT_FEED_EOB_EN) 3 beats (10,20,30) with coef_eob on the third -> one block out: row 0 = 10,20,0..., row 1 lane 0 = 30, all other lanes 0. A following full block shows no stale data.

Source files
------------

// File: rtl/idct_blk_feeder.sv
// rtl/idct_blk_feeder.sv - zigzag coefficient de-zigzag into ping-pong 8x8 banks, 8x32-bit row output.
// Optional early end-of-block input (coef_eob) enabled by defining IDCT_FEED_EOB_EN.
module idct_blk_feeder #(
    parameter int COEF_W = 16,
    parameter int LANE_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COEF_W-1:0]     coef_in,
    input  logic                  coef_valid,
`ifdef IDCT_FEED_EOB_EN
    input  logic                  coef_eob,
`endif
    output logic                  coef_ready,
    output logic [8*LANE_W-1:0]   row_data,
    output logic [2:0]            row_idx,
    output logic                  row_last,
    output logic                  row_valid,
    input  logic                  row_ready
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;
    localparam logic [1:0] ST_READING = 2'd3;

    localparam logic [5:0] ZZ_TO_NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [COEF_W-1:0]   bank_mem [2][64];

    logic [1:0]          st_q [2];
    logic [1:0]          st_d [2];
    logic                wr_bank_q, wr_bank_d;
    logic [5:0]          wr_cnt_q, wr_cnt_d;
    logic                rd_bank_q, rd_bank_d;
    logic [2:0]          rd_row_q, rd_row_d;
    logic                out_bank_q, out_bank_d;
    logic                row_valid_q, row_valid_d;
    logic [8*LANE_W-1:0] row_data_q, row_data_d;
    logic [2:0]          row_idx_q, row_idx_d;
    logic                row_last_q, row_last_d;

    logic                wr_fire, wr_done, out_fire, rd_load;
    logic [5:0]          wr_addr;
    logic [COEF_W-1:0]   rd_coef [8];
    logic [8*LANE_W-1:0] rd_lanes;

`ifdef IDCT_FEED_EOB_EN
    logic [63:0]         mask_q [2];
    logic [63:0]         mask_d [2];
    assign wr_done = (wr_cnt_q == 6'd63) || coef_eob;
`else
    assign wr_done = (wr_cnt_q == 6'd63);
`endif

    // FULL and READING both have bit 1 set; only those banks block writes and feed reads.
    assign coef_ready = ~st_q[wr_bank_q][1];
    assign wr_fire    = coef_valid && coef_ready;
    assign wr_addr    = ZZ_TO_NAT[wr_cnt_q];
    assign out_fire   = row_valid_q && row_ready;
    assign rd_load    = (!row_valid_q || row_ready) && st_q[rd_bank_q][1];

    always_comb begin
        rd_lanes = '0;
        for (int k = 0; k < 8; k++) begin
            rd_coef[k] = bank_mem[rd_bank_q][{rd_row_q, k[2:0]}];
`ifdef IDCT_FEED_EOB_EN
            if (!mask_q[rd_bank_q][{rd_row_q, k[2:0]}]) begin
                rd_coef[k] = '0;
            end
`endif
            rd_lanes[k*LANE_W +: LANE_W] = {{(LANE_W-COEF_W){rd_coef[k][COEF_W-1]}}, rd_coef[k]};
        end
    end

    always_comb begin
        st_d        = st_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        rd_row_d    = rd_row_q;
        out_bank_d  = out_bank_q;
        row_valid_d = row_valid_q;
        row_data_d  = row_data_q;
        row_idx_d   = row_idx_q;
        row_last_d  = row_last_q;
`ifdef IDCT_FEED_EOB_EN
        mask_d      = mask_q;
`endif
        if (wr_fire) begin
            st_d[wr_bank_q] = wr_done ? ST_FULL : ST_FILLING;
`ifdef IDCT_FEED_EOB_EN
            mask_d[wr_bank_q][wr_addr] = 1'b1;
`endif
            if (wr_done) begin
                wr_bank_d = ~wr_bank_q;
                wr_cnt_d  = '0;
            end else begin
                wr_cnt_d  = wr_cnt_q + 6'd1;
            end
        end
        if (out_fire && row_last_q) begin
            st_d[out_bank_q] = ST_EMPTY;
`ifdef IDCT_FEED_EOB_EN
            mask_d[out_bank_q] = '0;
`endif
        end
        // The read pointer moves to the other bank as soon as row 7 is loaded, so the
        // next block's row 0 can load in the same cycle row 7 is accepted.
        if (rd_load) begin
            row_valid_d     = 1'b1;
            row_data_d      = rd_lanes;
            row_idx_d       = rd_row_q;
            row_last_d      = (rd_row_q == 3'd7);
            out_bank_d      = rd_bank_q;
            st_d[rd_bank_q] = ST_READING;
            rd_row_d        = rd_row_q + 3'd1;
            if (rd_row_q == 3'd7) begin
                rd_bank_d = ~rd_bank_q;
            end
        end else if (out_fire) begin
            row_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_mem[wr_bank_q][wr_addr] <= coef_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]     <= ST_EMPTY;
            st_q[1]     <= ST_EMPTY;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_row_q    <= '0;
            out_bank_q  <= 1'b0;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            row_idx_q   <= '0;
            row_last_q  <= 1'b0;
`ifdef IDCT_FEED_EOB_EN
            mask_q[0]   <= '0;
            mask_q[1]   <= '0;
`endif
        end else begin
            st_q        <= st_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_row_q    <= rd_row_d;
            out_bank_q  <= out_bank_d;
            row_valid_q <= row_valid_d;
            row_data_q  <= row_data_d;
            row_idx_q   <= row_idx_d;
            row_last_q  <= row_last_d;
`ifdef IDCT_FEED_EOB_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign row_valid = row_valid_q;
    assign row_data  = row_data_q;
    assign row_idx   = row_idx_q;
    assign row_last  = row_last_q;

endmodule

// File: tb/tb_idct_blk_feeder.sv
// tb/tb_idct_blk_feeder.sv - directed bench for idct_blk_feeder with row scoreboard.
module tb_idct_blk_feeder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  coef_in = '0;
    logic         coef_valid = 1'b0;
    logic         coef_ready;
    logic [255:0] row_data;
    logic [2:0]   row_idx;
    logic         row_last;
    logic         row_valid;
    logic         row_ready = 1'b0;
`ifdef IDCT_FEED_EOB_EN
    logic         coef_eob = 1'b0;
`endif

    always #5 clk = ~clk;

    idct_blk_feeder #(.COEF_W(16), .LANE_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
`ifdef IDCT_FEED_EOB_EN
        .coef_eob   (coef_eob),
`endif
        .coef_ready (coef_ready),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .row_valid  (row_valid),
        .row_ready  (row_ready)
    );

    localparam int ZZ [64] = '{
        0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef struct {
        logic [255:0] data;
        logic [2:0]   idx;
        logic         last;
    } row_t;

    row_t         exp_q [$];
    logic [15:0]  cur_blk [64];
    int           wcnt = 0;
    int           cmp_cnt = 0;
    int           err_cnt = 0;
    logic [255:0] hold;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rows();
        row_t e;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                e.data[32*k +: 32] = {{16{cur_blk[r*8+k][15]}}, cur_blk[r*8+k]};
            end
            e.idx  = r[2:0];
            e.last = (r == 7);
            exp_q.push_back(e);
        end
        for (int n = 0; n < 64; n++) cur_blk[n] = '0;
    endtask

    task automatic send(input logic [15:0] v, input logic eob);
        int n = 0;
        coef_in    = v;
        coef_valid = 1'b1;
`ifdef IDCT_FEED_EOB_EN
        coef_eob   = eob;
`endif
        while (!coef_ready && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("send_timeout", coef_ready, 1);
        tick();
        cur_blk[ZZ[wcnt]] = v;
        if (wcnt == 63 || eob) begin
            wcnt = 0;
            push_rows();
        end else begin
            wcnt++;
        end
    endtask

    task automatic idle();
        coef_valid = 1'b0;
`ifdef IDCT_FEED_EOB_EN
        coef_eob   = 1'b0;
`endif
    endtask

    task automatic wait_row(input logic [2:0] idx);
        int n = 0;
        while (!(row_valid && row_idx == idx) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check("wait_row_timeout", {row_valid, row_idx}, {1'b1, idx});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("drain_timeout", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && row_valid && row_ready) begin
            check("sb_unexpected_row", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                row_t e;
                e = exp_q.pop_front();
                check("sb_row_data", row_data, e.data);
                check("sb_row_idx", row_idx, e.idx);
                check("sb_row_last", row_last, e.last);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 64; n++) cur_blk[n] = '0;
        repeat (3) tick();
        check("rst_row_valid", row_valid, 0);
        check("rst_row_data", row_data, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_row_last", row_last, 0);
        #2 rst_n = 1'b1;
        tick();
        check("rst_coef_ready", coef_ready, 1);

        // basic block, zigzag index as value
        row_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(16'(i), 1'b0);
        idle();
        check("t1_not_yet", row_valid, 0);
        tick();
        check("t1_first_valid", row_valid, 1);
        check("t1_row0", row_data, {32'd28, 32'd27, 32'd15, 32'd14, 32'd6, 32'd5, 32'd1, 32'd0});
        for (int r = 1; r < 8; r++) begin
            tick();
            check("t1_consec", {row_valid, row_idx}, {1'b1, r[2:0]});
            check("t1_last", row_last, (r == 7));
            if (r == 1) check("t1_row1_lane0", row_data[31:0], 32'd2);
            if (r == 7) check("t1_row7_lane7", row_data[255:224], 32'd63);
        end
        tick();
        check("t1_idle", row_valid, 0);

        // negative coefficient plus backpressure
        for (int i = 0; i < 64; i++) send((i == 2) ? 16'h8001 : 16'(100 + i), 1'b0);
        idle();
        wait_row(3'd1);
        check("t2_sign_ext", row_data[31:0], 32'hFFFF8001);
        wait_row(3'd2);
        row_ready = 1'b0;
        hold = row_data;
        repeat (20) begin
            tick();
            check("t3_stable_data", row_data, hold);
            check("t3_stable_idx", {row_valid, row_idx}, {1'b1, 3'd2});
        end
        row_ready = 1'b1;
        drain();

        // ping-pong stall with three blocks
        row_ready = 1'b0;
        for (int i = 0; i < 128; i++) send(16'(1000 + i * 7), 1'b0);
        idle();
        check("t4_stall", coef_ready, 0);
        repeat (3) tick();
        check("t4_stall_hold", coef_ready, 0);
        row_ready = 1'b1;
        begin
            int n = 0;
            while (!(row_valid && row_last) && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) check("t4_last_timeout", row_last, 1);
        end
        check("t4_ready_cycle_n", coef_ready, 0);
        tick();
        check("t4_ready_cycle_n1", coef_ready, 1);
        check("t4_seamless", {row_valid, row_idx}, {1'b1, 3'd0});
        for (int i = 0; i < 64; i++) send(16'(16'hF000 + i * 3), 1'b0);
        idle();
        drain();

        // async reset mid-read
        for (int i = 0; i < 64; i++) send(16'(500 - i), 1'b0);
        idle();
        wait_row(3'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", row_valid, 0);
        check("t5_rst_data", row_data, 0);
        check("t5_rst_idx", row_idx, 0);
        check("t5_rst_last", row_last, 0);
        exp_q.delete();
        wcnt = 0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
        check("t5_post_ready", coef_ready, 1);
        check("t5_post_valid", row_valid, 0);
        for (int i = 0; i < 64; i++) send(16'(i * 11 - 300), 1'b0);
        idle();
        tick();
        check("t5_fresh_row0", {row_valid, row_idx}, {1'b1, 3'd0});
        drain();

`ifdef IDCT_FEED_EOB_EN
        // early end-of-block
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b1);
        idle();
        tick();
        check("t6_eob_row0", row_data, {224'd0 | {32'd20, 32'd10}});
        drain();
        for (int i = 0; i < 64; i++) send(16'(2000 + i), 1'b0);
        idle();
        drain();
        send(16'd7, 1'b1);
        idle();
        tick();
        check("t6_eob_reuse_row0", row_data, {224'd0, 32'd7});
        drain();
`endif

        repeat (3) tick();
        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
